// File: rtl/spl_mem_responder_pkg.sv
// Shared widths and write-request decode for the SPL host-memory responder.
package spl_mem_responder_pkg;

  localparam int CL_W        = 512;
  localparam int ADDR_W      = 58;
  localparam int FENCE_CNT_W = 16;

  typedef logic [CL_W-1:0] cl_t;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_STORE = 2'd1,
    WR_FENCE = 2'd2
  } wr_op_e;

  // A fence rides on the write strobe; a lone fence flag means nothing.
  function automatic wr_op_e decode_wr(input logic wr_valid, input logic fence_valid);
    if (!wr_valid) return WR_NONE;
    return fence_valid ? WR_FENCE : WR_STORE;
  endfunction

endpackage

// File: rtl/spl_mem_responder_if.sv
// SPL TX/RX request/response bundle between afu_core (master) and host memory (slave).
interface spl_mem_responder_if;
  import spl_mem_responder_pkg::*;

  logic              cor_tx_rd_valid;
  logic [ADDR_W-1:0] cor_tx_rd_addr;
  logic              cor_tx_wr_valid;
  logic              cor_tx_fence_valid;
  logic [ADDR_W-1:0] cor_tx_wr_addr;
  cl_t               cor_tx_data;
  logic              spl_tx_rd_almostfull;
  logic              spl_tx_wr_almostfull;
  logic              io_rx_rd_valid;
  cl_t               io_rx_data;

  modport master (
    output cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_wr_valid, cor_tx_fence_valid,
           cor_tx_wr_addr, cor_tx_data,
    input  spl_tx_rd_almostfull, spl_tx_wr_almostfull, io_rx_rd_valid, io_rx_data
  );

  modport slave (
    input  cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_wr_valid, cor_tx_fence_valid,
           cor_tx_wr_addr, cor_tx_data,
    output spl_tx_rd_almostfull, spl_tx_wr_almostfull, io_rx_rd_valid, io_rx_data
  );

endinterface

// File: rtl/spl_cl_store.sv
// 1R/1W synchronous cache-line store; a same-edge read returns the pre-write contents.
module spl_cl_store
  import spl_mem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          CLK_400M,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cl_t           wdata,
  input  logic [AW-1:0] raddr,
  output cl_t           rdata
);

  cl_t mem [1 << AW];

  // Write and registered read share the edge; the read samples the array before the write lands.
  always_ff @(posedge CLK_400M) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spl_mem_responder.sv
// Host-memory responder: in-order fixed-latency read responses, write/fence sink, backpressure.
module spl_mem_responder
  import spl_mem_responder_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int RD_LAT    = 8,
  parameter int RQ_AW     = 5,
  parameter int AF_MARGIN = 8
) (
  input  logic                   CLK_400M,
  input  logic                   reset_n,
  spl_mem_responder_if.slave     bus,
  input  logic                   test_rd_stall,
  input  logic                   test_wr_stall,
  input  logic                   init_we,
  input  logic [MEM_AW-1:0]      init_addr,
  input  cl_t                    init_data,
  output logic [FENCE_CNT_W-1:0] fence_count,
  output logic                   rq_overflow
);

  localparam int RQ_DEPTH = 1 << RQ_AW;
  // One cycle in the queue and one in the store; the rest is padding before the output register.
  localparam int DLY = RD_LAT - 2;
  localparam logic [RQ_AW:0] RQ_FULL   = (RQ_AW+1)'(RQ_DEPTH);
  localparam logic [RQ_AW:0] RQ_AF_LVL = (RQ_AW+1)'(RQ_DEPTH - AF_MARGIN);

  function automatic logic [FENCE_CNT_W-1:0] sat_inc(input logic [FENCE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [MEM_AW-1:0] rq_mem [RQ_DEPTH];
  logic [RQ_AW-1:0]  rq_wptr, rq_rptr;
  logic [RQ_AW:0]    rq_cnt, rq_cnt_nxt;
  logic              rq_push, rq_pop;
  logic [MEM_AW-1:0] rd_idx;
  wr_op_e            wr_op;
  logic              st_we;
  logic [MEM_AW-1:0] st_waddr;
  cl_t               st_wdata;
  logic              vld_p0;
  cl_t               data_p0;
  logic              vld_p1  [DLY];
  cl_t               data_p1 [DLY];
  logic              unused_addr_hi;

  // A full queue still takes a request when an entry leaves on the same edge.
  assign rq_pop  = (rq_cnt != '0) && !test_rd_stall;
  assign rq_push = bus.cor_tx_rd_valid && ((rq_cnt != RQ_FULL) || rq_pop);
  assign rd_idx  = rq_mem[rq_rptr];

  // Preload port has priority over the core write port.
  assign wr_op    = decode_wr(bus.cor_tx_wr_valid, bus.cor_tx_fence_valid);
  assign st_we    = init_we || (wr_op == WR_STORE);
  assign st_waddr = init_we ? init_addr : bus.cor_tx_wr_addr[MEM_AW-1:0];
  assign st_wdata = init_we ? init_data : bus.cor_tx_data;

  // Address bits above the store index alias by design.
  assign unused_addr_hi = ^{bus.cor_tx_rd_addr[ADDR_W-1:MEM_AW],
                            bus.cor_tx_wr_addr[ADDR_W-1:MEM_AW]};

  // Queue occupancy after this edge.
  always_comb begin
    rq_cnt_nxt = rq_cnt;
    if (rq_push && !rq_pop)      rq_cnt_nxt = rq_cnt + 1'b1;
    else if (!rq_push && rq_pop) rq_cnt_nxt = rq_cnt - 1'b1;
  end

  // Request queue storage (store indices only).
  always_ff @(posedge CLK_400M) begin
    if (rq_push) rq_mem[rq_wptr] <= bus.cor_tx_rd_addr[MEM_AW-1:0];
  end

  // Queue pointers, overflow flag, backpressure and fence counter.
  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) begin
      rq_wptr                  <= '0;
      rq_rptr                  <= '0;
      rq_cnt                   <= '0;
      rq_overflow              <= 1'b0;
      bus.spl_tx_rd_almostfull <= 1'b0;
      bus.spl_tx_wr_almostfull <= 1'b0;
      fence_count              <= '0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)  rq_rptr <= rq_rptr + 1'b1;
      rq_cnt <= rq_cnt_nxt;
      if (bus.cor_tx_rd_valid && !rq_push) rq_overflow <= 1'b1;
      bus.spl_tx_rd_almostfull <= (rq_cnt_nxt >= RQ_AF_LVL) || test_rd_stall;
      bus.spl_tx_wr_almostfull <= test_wr_stall;
      if (wr_op == WR_FENCE) fence_count <= sat_inc(fence_count);
    end
  end

  // p0: store read of the popped index
  spl_cl_store #(.AW(MEM_AW)) u_store (
    .CLK_400M (CLK_400M),
    .we       (st_we),
    .waddr    (st_waddr),
    .wdata    (st_wdata),
    .raddr    (rd_idx),
    .rdata    (data_p0)
  );

  // Valid bits through the padding line to the output register; these always drain.
  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      for (int i = 0; i < DLY; i++) vld_p1[i] <= 1'b0;
      bus.io_rx_rd_valid <= 1'b0;
      bus.io_rx_data     <= '0;
    end else begin
      vld_p0    <= rq_pop;
      // p1: padding line
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < DLY; i++) vld_p1[i] <= vld_p1[i-1];
      // p2: response register; data holds between responses
      bus.io_rx_rd_valid <= vld_p1[DLY-1];
      if (vld_p1[DLY-1]) bus.io_rx_data <= data_p1[DLY-1];
    end
  end

  // Data side of the padding line.
  always_ff @(posedge CLK_400M) begin
    data_p1[0] <= data_p0;
    for (int i = 1; i < DLY; i++) data_p1[i] <= data_p1[i-1];
  end

endmodule

// File: tb/tb_spl_mem_responder.sv
// Bench for spl_mem_responder: queue/timestamp reference model plus directed sequences.
module tb_spl_mem_responder;
  import spl_mem_responder_pkg::*;

  localparam int MEM_AW    = 10;
  localparam int RD_LAT    = 8;
  localparam int RQ_AW     = 5;
  localparam int AF_MARGIN = 8;
  localparam int RQ_DEPTH  = 1 << RQ_AW;

  localparam cl_t PAT_A = {16{32'hAAAA_0005}};
  localparam cl_t PAT_B = {16{32'hBBBB_0006}};
  localparam cl_t PAT_D = {16{32'hDDDD_03FF}};

  logic              CLK_400M = 1'b0;
  logic              reset_n  = 1'b0;
  logic              test_rd_stall = 1'b0;
  logic              test_wr_stall = 1'b0;
  logic              init_we = 1'b0;
  logic [MEM_AW-1:0] init_addr = '0;
  cl_t               init_data = '0;
  logic [15:0]       fence_count;
  logic              rq_overflow;

  spl_mem_responder_if bus();

  spl_mem_responder #(
    .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .RQ_AW(RQ_AW), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .CLK_400M      (CLK_400M),
    .reset_n       (reset_n),
    .bus           (bus),
    .test_rd_stall (test_rd_stall),
    .test_wr_stall (test_wr_stall),
    .init_we       (init_we),
    .init_addr     (init_addr),
    .init_data     (init_data),
    .fence_count   (fence_count),
    .rq_overflow   (rq_overflow)
  );

  always #5 CLK_400M = ~CLK_400M;

  typedef struct { int t; cl_t d; } ev_t;
  typedef struct { logic [57:0] addr; cl_t exp; } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   chk_on = 1'b0;

  // Reference model state
  cl_t         mem_m [1 << MEM_AW];
  logic [9:0]  q_m[$];
  ev_t         sched_q[$];
  ev_t         rsp_q[$];
  logic        exp_vld = 1'b0, exp_rd_af = 1'b0, exp_wr_af = 1'b0, exp_ovf = 1'b0;
  cl_t         exp_data = '0;
  logic [15:0] exp_fence = '0;

  task automatic chk_cl(input string nm, input cl_t got, input cl_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic cl_t rnd_cl();
    cl_t d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: requests wait in a FIFO, one leaves per unstalled cycle, reads the
  // store as it was before that edge's write, and appears RD_LAT-1 edges after leaving.
  always @(posedge CLK_400M) begin
    cyc++;
    if (!reset_n) begin
      q_m.delete();
      sched_q.delete();
      exp_vld = 1'b0; exp_data = '0; exp_rd_af = 1'b0; exp_wr_af = 1'b0;
      exp_ovf = 1'b0; exp_fence = '0;
    end else begin
      if (q_m.size() > 0 && !test_rd_stall) begin
        ev_t s;
        s.t = cyc + RD_LAT - 1;
        s.d = mem_m[q_m.pop_front()];
        sched_q.push_back(s);
      end
      if (init_we) mem_m[init_addr] = init_data;
      else if (bus.cor_tx_wr_valid && !bus.cor_tx_fence_valid)
        mem_m[bus.cor_tx_wr_addr[9:0]] = bus.cor_tx_data;
      if (bus.cor_tx_wr_valid && bus.cor_tx_fence_valid && exp_fence != 16'hFFFF) exp_fence++;
      if (bus.cor_tx_rd_valid) begin
        if (q_m.size() < RQ_DEPTH) q_m.push_back(bus.cor_tx_rd_addr[9:0]);
        else exp_ovf = 1'b1;
      end
      exp_rd_af = (q_m.size() >= RQ_DEPTH - AF_MARGIN) || test_rd_stall;
      exp_wr_af = test_wr_stall;
      exp_vld = 1'b0;
      if (sched_q.size() > 0 && sched_q[0].t == cyc) begin
        exp_vld  = 1'b1;
        exp_data = sched_q[0].d;
        void'(sched_q.pop_front());
      end
    end
    #1;
    if (bus.io_rx_rd_valid) begin
      ev_t r;
      r.t = cyc;
      r.d = bus.io_rx_data;
      rsp_q.push_back(r);
    end
    if (chk_on) begin
      chk_int("model io_rx_rd_valid", int'(bus.io_rx_rd_valid), int'(exp_vld));
      chk_cl ("model io_rx_data", bus.io_rx_data, exp_data);
      chk_int("model rd_almostfull", int'(bus.spl_tx_rd_almostfull), int'(exp_rd_af));
      chk_int("model wr_almostfull", int'(bus.spl_tx_wr_almostfull), int'(exp_wr_af));
      chk_int("model rq_overflow", int'(rq_overflow), int'(exp_ovf));
      chk_int("model fence_count", int'(fence_count), int'(exp_fence));
    end
  end

  task automatic clr();
    bus.cor_tx_rd_valid    = 1'b0;
    bus.cor_tx_rd_addr     = '0;
    bus.cor_tx_wr_valid    = 1'b0;
    bus.cor_tx_fence_valid = 1'b0;
    bus.cor_tx_wr_addr     = '0;
    bus.cor_tx_data        = '0;
    init_we                = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK_400M);
      clr();
    end
  endtask

  task automatic drive(input logic rv, input logic [57:0] ra, input logic wv, input logic fv,
                       input logic [57:0] wa, input cl_t wd, output int e_n);
    @(negedge CLK_400M);
    clr();
    bus.cor_tx_rd_valid    = rv;
    bus.cor_tx_rd_addr     = ra;
    bus.cor_tx_wr_valid    = wv;
    bus.cor_tx_fence_valid = fv;
    bus.cor_tx_wr_addr     = wa;
    bus.cor_tx_data        = wd;
    e_n = cyc + 1;
  endtask

  task automatic rd(input logic [57:0] a, output int e_n);
    drive(1'b1, a, 1'b0, 1'b0, '0, '0, e_n);
  endtask

  task automatic wr(input logic [57:0] a, input cl_t d, input logic fence);
    int e_n;
    drive(1'b0, '0, 1'b1, fence, a, d, e_n);
  endtask

  task automatic pre(input int idx, input cl_t d);
    @(negedge CLK_400M);
    clr();
    init_we   = 1'b1;
    init_addr = 10'(idx);
    init_data = d;
  endtask

  // Single read with nothing else in flight: exactly one response, RD_LAT after sampling.
  task automatic single_read(input string nm, input logic [57:0] a, input cl_t exp);
    int e;
    rsp_q.delete();
    rd(a, e);
    idle(RD_LAT + 3);
    chk_int({nm, " count"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      chk_int({nm, " latency"}, rsp_q[0].t - e, RD_LAT);
      chk_cl ({nm, " data"}, rsp_q[0].d, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    cl_t  exp_at[32];
    cl_t  old_v, new_v, fd;
    int   e0, e1, e;

    clr();
    repeat (3) @(negedge CLK_400M);
    chk_int("reset io_rx_rd_valid", int'(bus.io_rx_rd_valid), 0);
    chk_cl ("reset io_rx_data", bus.io_rx_data, '0);
    chk_int("reset rd_almostfull", int'(bus.spl_tx_rd_almostfull), 0);
    chk_int("reset wr_almostfull", int'(bus.spl_tx_wr_almostfull), 0);
    chk_int("reset fence_count", int'(fence_count), 0);
    chk_int("reset rq_overflow", int'(rq_overflow), 0);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    for (int i = 0; i < (1 << MEM_AW); i++) pre(i, rnd_cl());
    pre(5, PAT_A);
    pre(6, PAT_B);
    pre(10'h3FF, PAT_D);
    idle(2);

    // Two back-to-back reads come back on consecutive cycles, RD_LAT after each request.
    rsp_q.delete();
    rd(58'h5, e0);
    rd(58'h6, e1);
    idle(RD_LAT + 6);
    chk_int("pair count", rsp_q.size(), 2);
    if (rsp_q.size() > 1) begin
      chk_int("pair first edge", rsp_q[0].t, e0 + RD_LAT);
      chk_cl ("pair first data", rsp_q[0].d, PAT_A);
      chk_int("pair second edge", rsp_q[1].t, e1 + RD_LAT);
      chk_cl ("pair second data", rsp_q[1].d, PAT_B);
    end

    tbl[0] = '{addr: 58'h5,              exp: PAT_A};
    tbl[1] = '{addr: 58'h6,              exp: PAT_B};
    tbl[2] = '{addr: 58'h405,            exp: PAT_A};
    tbl[3] = '{addr: 58'h2AB00000000006, exp: PAT_B};
    tbl[4] = '{addr: 58'h3FF,            exp: PAT_D};
    tbl[5] = '{addr: 58'h7FF,            exp: PAT_D};
    for (int i = 0; i < 6; i++) single_read($sformatf("table[%0d]", i), tbl[i].addr, tbl[i].exp);

    // Fill past capacity under stall, then drain.
    test_rd_stall = 1'b1;
    rsp_q.delete();
    for (int i = 0; i < 40; i++) rd(58'(100 + i), e);
    idle(2);
    for (int i = 0; i < 32; i++) exp_at[i] = mem_m[100 + i];
    chk_int("stall overflow sticky", int'(rq_overflow), 1);
    chk_int("stall rd_almostfull", int'(bus.spl_tx_rd_almostfull), 1);
    chk_int("stall no responses", rsp_q.size(), 0);
    test_rd_stall = 1'b0;
    idle(RD_LAT + 50);
    chk_int("drain count", rsp_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      if (i < rsp_q.size()) begin
        chk_cl ($sformatf("drain data[%0d]", i), rsp_q[i].d, exp_at[i]);
        chk_int($sformatf("drain edge[%0d]", i), rsp_q[i].t - rsp_q[0].t, i);
      end
    end
    chk_int("overflow still sticky", int'(rq_overflow), 1);

    // Aliased write, read two cycles after the write edge.
    new_v = rnd_cl();
    wr(58'h7FF, new_v, 1'b0);
    idle(1);
    single_read("alias write readback", 58'h3FF, new_v);

    // Write on the same edge the store reads index 7: old data comes back.
    old_v = mem_m[7];
    new_v = rnd_cl();
    rsp_q.delete();
    rd(58'h7, e);
    wr(58'h7, new_v, 1'b0);
    idle(RD_LAT + 3);
    chk_int("collision count", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk_cl("collision old data", rsp_q[0].d, old_v);
    single_read("collision then new", 58'h7, new_v);

    // Fences interleaved with normal writes.
    old_v = mem_m[0];
    fd = '0;
    fd[511] = 1'b1;
    wr(58'h0, fd, 1'b1);
    wr(58'd20, rnd_cl(), 1'b0);
    wr(58'h0, fd, 1'b1);
    wr(58'd21, rnd_cl(), 1'b0);
    wr(58'h0, fd, 1'b1);
    idle(2);
    chk_int("fence_count after 3", int'(fence_count), 3);
    single_read("fence leaves index 0", 58'h0, old_v);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra, wa;
      logic rv, wv, fv;
      ra = {$urandom, $urandom};
      wa = {$urandom, $urandom};
      rv = ($urandom_range(0, 99) < 70);
      wv = ($urandom_range(0, 99) < 40);
      fv = ($urandom_range(0, 99) < 20);
      test_rd_stall = ($urandom_range(0, 99) < 30);
      drive(rv, ra[57:0], wv, fv, wa[57:0], rnd_cl(), e);
    end
    test_rd_stall = 1'b0;
    idle(RD_LAT + 50);

    // Reset with six responses in flight.
    rsp_q.delete();
    for (int i = 0; i < 6; i++) rd(58'(200 + i), e);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(RD_LAT + 6);
    chk_int("reset drops in-flight", rsp_q.size(), 0);
    chk_int("reset fence_count", int'(fence_count), 0);
    chk_int("reset clears overflow", int'(rq_overflow), 0);
    single_read("read after reset", 58'd300, mem_m[300]);

    // Write backpressure is a registered copy of test_wr_stall; writes still land.
    chk_int("wr_almostfull idle", int'(bus.spl_tx_wr_almostfull), 0);
    test_wr_stall = 1'b1;
    @(posedge CLK_400M);
    #1;
    chk_int("wr_almostfull one cycle later", int'(bus.spl_tx_wr_almostfull), 1);
    new_v = rnd_cl();
    wr(58'd30, new_v, 1'b0);
    idle(1);
    single_read("write during wr stall", 58'd30, new_v);
    test_wr_stall = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spl_mem_responder.md
Name: spl_mem_responder

Overview:
- Host-memory responder model for the 400 MHz SPL TX/RX interface: the far end of the afu_core request/response protocol.
- Accepts read requests (cor_tx_rd_*), queues them, and returns 512-bit cache lines on io_rx_rd_valid/io_rx_data in strict request order with fixed latency.
- Applies write requests (cor_tx_wr_*) to an internal cache-line store and consumes fences.
- Drives spl_tx_rd_almostfull/spl_tx_wr_almostfull backpressure; used in simulation benches and as an on-chip loopback memory.

Parameters:
MEM_AW, 10, cache-line store address width (2^MEM_AW lines of 512 bits)
RD_LAT, 8, cycles from request sample edge to response valid, unloaded; legal range 3..32
RQ_AW, 5, read request queue address width (depth 2^RQ_AW)
AF_MARGIN, 8, free-slot margin at which spl_tx_rd_almostfull asserts

Ports:
CLK_400M  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
cor_tx_rd_valid  in  1  read request strobe
cor_tx_rd_addr  in  58  cache-line read address
cor_tx_wr_valid  in  1  write request strobe
cor_tx_fence_valid  in  1  marks the current write as a fence
cor_tx_wr_addr  in  58  cache-line write address
cor_tx_data  in  512  write data
spl_tx_rd_almostfull  out  1  read backpressure
spl_tx_wr_almostfull  out  1  write backpressure
io_rx_rd_valid  out  1  read response strobe
io_rx_data  out  512  read response data
test_rd_stall  in  1  forces rd almostfull and freezes response issue
test_wr_stall  in  1  forces wr almostfull
init_we  in  1  bench preload write enable
init_addr  in  MEM_AW  preload index
init_data  in  512  preload data
fence_count  out  16  number of fences consumed
rq_overflow  out  1  sticky: request arrived while queue full

Behaviour:
- Reset: asynchronous on reset_n low. All outputs 0; queue pointers, delay line, fence_count and rq_overflow cleared. Store contents are not reset. Reset mid-operation drops all in-flight responses; no io_rx_rd_valid until new requests arrive.
- Read accept: each cycle with cor_tx_rd_valid=1, the address is pushed into the request queue.
  - If the queue is full, the request is dropped and rq_overflow is set (sticky until reset).
  - A push and a pop in the same cycle are both honoured.
- spl_tx_rd_almostfull is registered: 1 when occupancy >= 2^RQ_AW - AF_MARGIN, or when test_rd_stall=1.
- Issue: when the queue is non-empty and test_rd_stall=0, one entry is popped per cycle. Store index = addr[MEM_AW-1:0]; upper bits are ignored (aliasing wraps).
- Read path: synchronous store read (1 cycle), then a delay line padding the total to exactly RD_LAT cycles when the queue was empty and no stall was present. A request sampled at edge N gives io_rx_rd_valid=1 at edge N+RD_LAT.
- Ordering: responses are strictly in request order, one per cycle maximum. The receiver assigns k/l by parity, so reordering is forbidden.
- Under test_rd_stall=1: pops stop; entries already in the delay line still drain.
- io_rx_data holds the last value when io_rx_rd_valid=0.
- Write: cor_tx_wr_valid=1 with cor_tx_fence_valid=0 writes cor_tx_data to index cor_tx_wr_addr[MEM_AW-1:0] on that edge.
- Fence: cor_tx_wr_valid=1 with cor_tx_fence_valid=1 performs no store write and increments fence_count, which saturates at 0xFFFF.
- Read-after-write: a read popped on a cycle after the write edge sees the new data. A read and write to the same index on the same edge returns the old data.
- Write port arbitration: if init_we and cor_tx_wr_valid collide, init_we wins and the core write is dropped. This is bench-only usage.
- spl_tx_wr_almostfull is registered test_wr_stall. Writes arriving while it is asserted are still accepted (the core has in-flight slack).
- cor_tx_fence_valid without cor_tx_wr_valid is ignored.

Decomposition:
- Shared package: CL_W=512, ADDR_W=58, and a fence_count width constant.
- One sub-module: spl_cl_store, a 1-read/1-write synchronous 512-bit RAM with read-old-on-collision semantics.
- The request queue and delay line stay inline.

Test Plan:
- Preload index 5=A, index 6=B; request addr 5 at edge 10 and addr 6 at edge 11 -> valid at edges 18 (A) and 19 (B), no other valid cycles.
- 40 back-to-back reads with test_rd_stall=1 -> almostfull asserts once occupancy reaches 24; at 32 entries rq_overflow=1 and requests 33..40 are dropped. Release stall -> exactly 32 in-order responses.
- Write C to addr 0x3FF+0x400 (aliases to 0x3FF), then read 0x3FF two cycles later -> response C. Same-edge write/read to index 7 -> old data.
- Three fence writes (addr 0, data[511]=1) interleaved with normal writes -> fence_count=3, store index 0 unchanged.
- Pulse reset_n low for 1 cycle while 6 responses are in flight -> no io_rx_rd_valid afterwards, fence_count=0. A new read afterwards returns after exactly RD_LAT cycles.
- test_wr_stall=1 -> spl_tx_wr_almostfull=1 one cycle later; a write issued during the stall is still stored and read back correctly.
